// File: rtl/square_pkg.sv
// Shared definitions for the sequential squarer. The state encoding matches the
// sqrt unit so the two can sit side by side in the Lab2 datapath.
package square_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int result_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/square.sv
// Sequential unsigned squarer y = x*x: one shift-add step per clock, fixed
// WIDTH-cycle latency, start/busy handshake shared with the sqrt unit.
module square
  import square_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     x_bi,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic [2*WIDTH-1:0]   y_bo
);

  localparam int RW = result_width(WIDTH);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t          state, state_n;
  logic [RW-1:0]   acc, acc_n;
  logic [RW-1:0]   mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [RW-1:0]   y_q, y_n;
  logic [RW-1:0]   sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      y_q    <= '0;
    end else begin
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      cnt    <= cnt_n;
      y_q    <= y_n;
    end
  end

  // The finishing step publishes sum directly, so no extra cycle is spent copying acc.
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    cnt_n    = cnt;
    y_n      = y_q;
    sum      = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (start_i) begin
          mcand_n  = {{WIDTH{1'b0}}, x_bi};
          mplier_n = x_bi;
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = WORK;
        end
      end
      WORK: begin
        acc_n    = sum;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          y_n     = sum;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o = (state == WORK);
  assign y_bo   = y_q;

endmodule
